scoreboard_counted: RTL and testbench

SCOREBOARD_COUNTED -- requirements
Module: scoreboard_counted

---
 rtl/scoreboard_counted.sv | 171 +++++++++++++++++
 tb/tb_scoreboard_counted.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_counted.sv
// Counted scoreboard: one staging slot per warp, a pending-write counter per (warp, register),
// and round-robin issue of hazard-free instructions into a single registered output stage.
module scoreboard_counted #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64,
  parameter int NUM_SRCS  = 3,
  parameter int NUM_WB    = 2,
  parameter int MAX_PEND  = 3,
  parameter int DATAW     = 64,
  localparam int RW = $clog2(NUM_REGS),
  localparam int CW = $clog2(MAX_PEND + 1),
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_WARPS-1:0]             in_valid,
  output logic [NUM_WARPS-1:0]             in_ready,
  input  logic [NUM_WARPS-1:0]             in_wb,
  input  logic [NUM_WARPS*RW-1:0]          in_rd,
  input  logic [NUM_WARPS*NUM_SRCS*RW-1:0] in_rs,
  input  logic [NUM_WARPS*DATAW-1:0]       in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WW-1:0]                    out_wid,
  output logic                             out_wb,
  output logic [RW-1:0]                    out_rd,
  output logic [DATAW-1:0]                 out_data,
  input  logic [NUM_WB-1:0]                wb_valid,
  input  logic [NUM_WB*WW-1:0]             wb_wid,
  input  logic [NUM_WB*RW-1:0]             wb_rd,
  output logic                             err_underflow
);

  logic [NUM_WARPS-1:0] slot_valid;
  logic [NUM_WARPS-1:0] slot_wb;
  logic [RW-1:0]        slot_rd   [NUM_WARPS];
  logic [RW-1:0]        slot_rs   [NUM_WARPS][NUM_SRCS];
  logic [DATAW-1:0]     slot_data [NUM_WARPS];

  logic [CW-1:0] cnt      [NUM_WARPS][NUM_REGS];
  logic [CW-1:0] cnt_next [NUM_WARPS][NUM_REGS];

  logic [WW-1:0]        rr_ptr;
  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] grant;
  logic                 grant_any;
  logic [WW-1:0]        grant_wid;
  logic [WW-1:0]        cand;
  logic                 can_issue;
  logic                 issue_wb;
  logic [RW-1:0]        issue_rd;
  logic                 underflow_now;

  logic [WW-1:0] wb_wid_a [NUM_WB];
  logic [RW-1:0] wb_rd_a  [NUM_WB];

  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      wb_wid_a[p] = wb_wid[p*WW +: WW];
      wb_rd_a[p]  = wb_rd[p*RW +: RW];
    end
  end

  // Hazard check looks only at registered counters, so a writeback unblocks a reader one cycle later.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = slot_valid[w];
      for (int s = 0; s < NUM_SRCS; s++) begin
        if (cnt[w][slot_rs[w][s]] != '0) eligible[w] = 1'b0;
      end
      if (slot_wb[w] && int'(cnt[w][slot_rd[w]]) >= MAX_PEND) eligible[w] = 1'b0;
    end
  end

  assign can_issue = !out_valid || out_ready;

  always_comb begin
    grant_any = 1'b0;
    grant_wid = '0;
    cand      = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      cand = WW'((int'(rr_ptr) + i) % NUM_WARPS);
      if (can_issue && !grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_wid = cand;
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      grant[w] = grant_any && (int'(grant_wid) == w);
    end
  end

  assign in_ready = {NUM_WARPS{reset}} & (~slot_valid | grant);
  assign issue_wb = grant_any && slot_wb[grant_wid];
  assign issue_rd = slot_rd[grant_wid];

  // NOTE: v is a blocking scratch accumulator, re-seeded per counter before use, so no latch forms.
  always_comb begin : p_cnt_next
    int v;
    v             = 0;
    underflow_now = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        v = int'(cnt[w][r]);
        if (issue_wb && int'(grant_wid) == w && int'(issue_rd) == r) v = v + 1;
        for (int p = 0; p < NUM_WB; p++) begin
          if (wb_valid[p] && int'(wb_wid_a[p]) == w && int'(wb_rd_a[p]) == r) v = v - 1;
        end
        if (v < 0) begin
          v             = 0;
          underflow_now = 1'b1;
        end
        cnt_next[w][r] = CW'(v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_valid    <= '0;
      rr_ptr        <= '0;
      out_valid     <= 1'b0;
      out_wid       <= '0;
      out_wb        <= 1'b0;
      out_rd        <= '0;
      out_data      <= '0;
      err_underflow <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          cnt[w][r] <= '0;
        end
      end
    end else begin
      slot_valid    <= (slot_valid & ~grant) | (in_valid & in_ready);
      err_underflow <= err_underflow | underflow_now;
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          cnt[w][r] <= cnt_next[w][r];
        end
      end
      if (grant_any) begin
        out_valid <= 1'b1;
        out_wid   <= grant_wid;
        out_wb    <= slot_wb[grant_wid];
        out_rd    <= slot_rd[grant_wid];
        out_data  <= slot_data[grant_wid];
        rr_ptr    <= WW'((int'(grant_wid) + 1) % NUM_WARPS);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // NOTE: slot payload has no reset; slot_valid qualifies it, so clearing the valid bits suffices.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (in_valid[w] && in_ready[w]) begin
        slot_wb[w]   <= in_wb[w];
        slot_rd[w]   <= in_rd[w*RW +: RW];
        slot_data[w] <= in_data[w*DATAW +: DATAW];
        for (int s = 0; s < NUM_SRCS; s++) begin
          slot_rs[w][s] <= in_rs[(w*NUM_SRCS + s)*RW +: RW];
        end
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_counted.sv
// Directed bench for scoreboard_counted: RAW, WAW, same-cycle issue/writeback, dual writeback,
// underflow, backpressure, mid-stream reset and round-robin fairness.
module tb_scoreboard_counted;
  localparam int NUM_WARPS = 4;
  localparam int NUM_REGS  = 64;
  localparam int NUM_SRCS  = 3;
  localparam int NUM_WB    = 2;
  localparam int MAX_PEND  = 3;
  localparam int DATAW     = 64;
  localparam int RW        = 6;
  localparam int WW        = 2;

  logic                             clk = 1'b0;
  logic                             reset;
  logic [NUM_WARPS-1:0]             in_valid;
  logic [NUM_WARPS-1:0]             in_ready;
  logic [NUM_WARPS-1:0]             in_wb;
  logic [NUM_WARPS*RW-1:0]          in_rd;
  logic [NUM_WARPS*NUM_SRCS*RW-1:0] in_rs;
  logic [NUM_WARPS*DATAW-1:0]       in_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [WW-1:0]                    out_wid;
  logic                             out_wb;
  logic [RW-1:0]                    out_rd;
  logic [DATAW-1:0]                 out_data;
  logic [NUM_WB-1:0]                wb_valid;
  logic [NUM_WB*WW-1:0]             wb_wid;
  logic [NUM_WB*RW-1:0]             wb_rd;
  logic                             err_underflow;

  int errors = 0;
  int checks = 0;

  scoreboard_counted #(
    .NUM_WARPS(NUM_WARPS), .NUM_REGS(NUM_REGS), .NUM_SRCS(NUM_SRCS),
    .NUM_WB(NUM_WB), .MAX_PEND(MAX_PEND), .DATAW(DATAW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wb(in_wb), .in_rd(in_rd),
    .in_rs(in_rs), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_wb(out_wb),
    .out_rd(out_rd), .out_data(out_data),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Offers one instruction on warp w (extra sources point at never-written r63) and checks acceptance.
  task automatic put(input int w, input logic wb, input logic [RW-1:0] rd,
                     input logic [RW-1:0] rs0, input logic [DATAW-1:0] data);
    in_wb[w]                        = wb;
    in_rd[w*RW +: RW]               = rd;
    in_rs[(w*NUM_SRCS)*RW +: RW]    = rs0;
    for (int s = 1; s < NUM_SRCS; s++) in_rs[(w*NUM_SRCS + s)*RW +: RW] = 6'd63;
    in_data[w*DATAW +: DATAW]       = data;
    in_valid[w]                     = 1'b1;
    check($sformatf("accept_w%0d_%0h", w, data), 64'(in_ready[w]), 64'd1);
  endtask

  task automatic drop(input int w);
    in_valid[w] = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [WW-1:0] wid, input logic [RW-1:0] rd);
    wb_valid[p]           = 1'b1;
    wb_wid[p*WW +: WW]    = wid;
    wb_rd[p*RW +: RW]     = rd;
  endtask

  task automatic clear_wb();
    wb_valid = '0;
  endtask

  task automatic check_out(input string tag, input int wid, input logic [DATAW-1:0] data);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_wid"},   64'(out_wid),   64'(wid));
    check({tag, "_data"},  out_data,       data);
  endtask

  int fair_wid [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset     = 1'b0;
    in_valid  = '0;
    in_wb     = '0;
    in_rd     = '0;
    in_rs     = '1;
    in_data   = '0;
    out_ready = 1'b1;
    wb_valid  = '0;
    wb_wid    = '0;
    wb_rd     = '0;

    // Reset state
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_err",       64'(err_underflow), 64'd0);
    check("rst_out_wid",   64'(out_wid),   64'd0);
    check("rst_out_data",  out_data,       64'd0);
    reset = 1'b1;
    step();
    check("idle_in_ready", 64'(in_ready), 64'hF);

    // RAW on warp0 r5, plus two-cycle latency
    put(0, 1'b1, 6'd5, 6'd63, 64'h100);
    step();
    check("lat_not_yet", 64'(out_valid), 64'd0);
    put(0, 1'b0, 6'd0, 6'd5, 64'h101);
    step();
    drop(0);
    check_out("raw_first", 0, 64'h100);
    check("raw_first_wb", 64'(out_wb), 64'd1);
    check("raw_first_rd", 64'(out_rd), 64'd5);
    check("raw_blocked_ready", 64'(in_ready[0]), 64'd0);
    step();
    check("raw_hold1", 64'(out_valid), 64'd0);
    step();
    check("raw_hold2", 64'(out_valid), 64'd0);
    set_wb(0, 2'd0, 6'd5);
    step();
    clear_wb();
    check("raw_wb_cycle_after", 64'(out_valid), 64'd0);
    step();
    check_out("raw_second", 0, 64'h101);
    check("raw_second_wb", 64'(out_wb), 64'd0);
    step();

    // WAW: four writes to warp1 r7, the fourth waits for one writeback
    put(1, 1'b1, 6'd7, 6'd63, 64'h200);
    step();
    put(1, 1'b1, 6'd7, 6'd63, 64'h201);
    step();
    check_out("waw0", 1, 64'h200);
    put(1, 1'b1, 6'd7, 6'd63, 64'h202);
    step();
    check_out("waw1", 1, 64'h201);
    put(1, 1'b1, 6'd7, 6'd63, 64'h203);
    step();
    drop(1);
    check_out("waw2", 1, 64'h202);
    check("waw_full_ready", 64'(in_ready[1]), 64'd0);
    step();
    check("waw_stall1", 64'(out_valid), 64'd0);
    step();
    check("waw_stall2", 64'(out_valid), 64'd0);
    set_wb(1, 2'd1, 6'd7);
    step();
    clear_wb();
    check("waw_stall3", 64'(out_valid), 64'd0);
    step();
    check_out("waw3", 1, 64'h203);
    step();

    // Issue and writeback to warp2 r2 in the same cycle keep the counter at 1
    put(2, 1'b1, 6'd2, 6'd63, 64'h300);
    step();
    put(2, 1'b1, 6'd2, 6'd63, 64'h301);
    step();
    check_out("r2_w0", 2, 64'h300);
    put(2, 1'b0, 6'd0, 6'd2, 64'h302);
    set_wb(0, 2'd2, 6'd2);
    step();
    drop(2);
    clear_wb();
    check_out("r2_w1", 2, 64'h301);
    step();
    check("r2_cnt_kept", 64'(out_valid), 64'd0);
    set_wb(0, 2'd2, 6'd2);
    step();
    clear_wb();
    check("r2_wait", 64'(out_valid), 64'd0);
    step();
    check_out("r2_read", 2, 64'h302);
    step();

    // Dual-port writeback on warp3 r2: counter 2 -> 0 in one cycle
    put(3, 1'b1, 6'd2, 6'd63, 64'h400);
    step();
    put(3, 1'b1, 6'd2, 6'd63, 64'h401);
    step();
    check_out("dual_w0", 3, 64'h400);
    put(3, 1'b0, 6'd0, 6'd2, 64'h402);
    step();
    drop(3);
    check_out("dual_w1", 3, 64'h401);
    set_wb(0, 2'd3, 6'd2);
    set_wb(1, 2'd3, 6'd2);
    step();
    clear_wb();
    check("dual_wait", 64'(out_valid), 64'd0);
    step();
    check_out("dual_read", 3, 64'h402);
    check("dual_no_err", 64'(err_underflow), 64'd0);
    step();

    // Underflow on warp0 r9: flag sticks, counter stays at 0
    check("uf_before", 64'(err_underflow), 64'd0);
    set_wb(1, 2'd0, 6'd9);
    step();
    clear_wb();
    check("uf_set", 64'(err_underflow), 64'd1);
    put(0, 1'b0, 6'd0, 6'd9, 64'h500);
    step();
    drop(0);
    check("uf_hold", 64'(err_underflow), 64'd1);
    step();
    check_out("uf_cnt_zero", 0, 64'h500);
    check("uf_hold2", 64'(err_underflow), 64'd1);
    step();

    // Backpressure: output held for five cycles, then mid-stream reset
    out_ready = 1'b0;
    put(1, 1'b0, 6'd0, 6'd63, 64'h600);
    put(2, 1'b0, 6'd0, 6'd63, 64'h601);
    step();
    drop(1);
    drop(2);
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("bp_hold%0d", i), 1, 64'h600);
      check($sformatf("bp_w2_ready%0d", i), 64'(in_ready[2]), 64'd0);
    end
    out_ready = 1'b1;
    put(3, 1'b1, 6'd10, 6'd63, 64'h700);
    step();
    drop(3);
    check_out("bp_release", 2, 64'h601);
    reset = 1'b0;
    step();
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_wid",   64'(out_wid),   64'd0);
    check("mrst_out_wb",    64'(out_wb),    64'd0);
    check("mrst_out_rd",    64'(out_rd),    64'd0);
    check("mrst_out_data",  out_data,       64'd0);
    check("mrst_err",       64'(err_underflow), 64'd0);
    check("mrst_in_ready",  64'(in_ready),  64'd0);
    reset = 1'b1;
    step();
    check("mrst_ready_back", 64'(in_ready), 64'hF);
    check("mrst_discard", 64'(out_valid), 64'd0);
    set_wb(0, 2'd3, 6'd10);
    step();
    clear_wb();
    check("mrst_late_wb_err", 64'(err_underflow), 64'd1);
    check("mrst_discard2", 64'(out_valid), 64'd0);

    // Fairness: all warps eligible right after reset -> 0,1,2,3,0
    for (int w = 0; w < NUM_WARPS; w++) put(w, 1'b0, 6'd0, 6'd63, 64'h800 + 64'(w));
    step();
    for (int w = 1; w < NUM_WARPS; w++) drop(w);
    put(0, 1'b0, 6'd0, 6'd63, 64'h804);
    step();
    drop(0);
    for (int i = 0; i < 5; i++) begin
      check_out($sformatf("fair%0d", i), fair_wid[i], 64'h800 + 64'(i));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
